// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, tap positions, FSM encoding and step functions for the ALU BIST
package alu_pkg;

    localparam int WORD_W = 20;
    localparam int LFSR_W = 40;
    localparam int SIG_W  = 21;
    localparam int CNT_W  = 10;

    // x^40 + x^38 + x^21 + x^19 + 1
    localparam int LFSR_TAP0 = 39;
    localparam int LFSR_TAP1 = 37;
    localparam int LFSR_TAP2 = 20;
    localparam int LFSR_TAP3 = 18;

    // x^21 + x^19 + 1
    localparam int MISR_TAP0 = 20;
    localparam int MISR_TAP1 = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0],
                cur[LFSR_TAP0] ^ cur[LFSR_TAP1] ^ cur[LFSR_TAP2] ^ cur[LFSR_TAP3]};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                   input logic [SIG_W-1:0] din);
        return {cur[SIG_W-2:0], cur[MISR_TAP0] ^ cur[MISR_TAP1]} ^ din;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - 21-bit multiple-input signature register shared by the logic and arith BISTs
module bist_misr
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Clear wins over enable so a restart never folds in a stale result.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_step(sig_q, din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/alu_logic_bist.sv
// rtl/alu_logic_bist.sv - LFSR-driven self-test controller for the 20-bit ALU logic units
module alu_logic_bist
    import alu_pkg::*;
#(
    parameter int                NUM_VECTORS = 10,
    parameter logic [LFSR_W-1:0] SEED        = 40'h00000_00001,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG  = 21'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    input  logic [WORD_W-1:0] res_c,
    input  logic              res_zero,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature
);

    if (SEED == '0) begin : g_bad_seed
        $error("alu_logic_bist: SEED must be nonzero");
    end
    if (NUM_VECTORS < 1 || NUM_VECTORS > 1023) begin : g_bad_count
        $error("alu_logic_bist: NUM_VECTORS must be 1..1023");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS - 1);

    bist_state_e       state_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;

    logic              launch;
    logic              misr_en;
    logic [SIG_W-1:0]  sig;

    assign launch  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign misr_en = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        lfsr_q  <= SEED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    bist_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (misr_en),
        .din ({res_zero, res_c}),
        .sig (sig)
    );

    assign op_a      = lfsr_q[LFSR_W-1:WORD_W];
    assign op_b      = lfsr_q[WORD_W-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && (sig == GOLDEN_SIG);
    assign signature = sig;

endmodule

// File: tb/tb_alu_logic_bist.sv
// tb/tb_alu_logic_bist.sv - bench for alu_logic_bist with xor_word attached to three configurations
module tb_alu_logic_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_w    [3];
    logic        fault_w    [3];
    logic [19:0] op_a_w     [3];
    logic [19:0] op_b_w     [3];
    logic [19:0] res_c_w    [3];
    logic        res_zero_w [3];
    logic        busy_w     [3];
    logic        done_w     [3];
    logic        pass_w     [3];
    logic [20:0] sig_w      [3];

    int tests = 0;
    int fails = 0;

    logic [39:0] exp_op_q  [$];
    logic [20:0] exp_sig_q [$];

    alu_logic_bist #(.NUM_VECTORS(1), .SEED(40'h1), .GOLDEN_SIG(21'h000001)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[0]), .op_a(op_a_w[0]), .op_b(op_b_w[0]),
        .res_c(res_c_w[0]), .res_zero(res_zero_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .signature(sig_w[0]));

    alu_logic_bist #(.NUM_VECTORS(2), .SEED(40'h1), .GOLDEN_SIG(21'h000000)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_w[1]), .op_a(op_a_w[1]), .op_b(op_b_w[1]),
        .res_c(res_c_w[1]), .res_zero(res_zero_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .signature(sig_w[1]));

    alu_logic_bist #(.NUM_VECTORS(10), .SEED(40'hA5A5A_5C3C3), .GOLDEN_SIG(21'h000000)) u_dut10 (
        .clk(clk), .rst(rst), .start(start_w[2]), .op_a(op_a_w[2]), .op_b(op_b_w[2]),
        .res_c(res_c_w[2]), .res_zero(res_zero_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .signature(sig_w[2]));

    // xor_word unit under test; fault_w stuck-at-zeros its result word
    for (genvar g = 0; g < 3; g++) begin : g_uut
        assign res_c_w[g]    = fault_w[g] ? 20'h0 : (op_a_w[g] ^ op_b_w[g]);
        assign res_zero_w[g] = ((op_a_w[g] ^ op_b_w[g]) == 20'h0);
    end

    function automatic int nv_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 10;
        endcase
    endfunction

    function automatic logic [39:0] seed_of(input int i);
        return (i == 2) ? 40'hA5A5A_5C3C3 : 40'h1;
    endfunction

    function automatic logic [20:0] gold_of(input int i);
        return (i == 0) ? 21'h000001 : 21'h000000;
    endfunction

    function automatic logic [39:0] model_lfsr(input logic [39:0] v);
        return {v[38:0], v[39] ^ v[37] ^ v[20] ^ v[18]};
    endfunction

    function automatic logic [20:0] model_misr(input logic [20:0] s, input logic [20:0] d);
        return {s[19:0], s[20] ^ s[18]} ^ d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_expect(input int i, input bit fault);
        logic [39:0] l;
        logic [20:0] s;
        logic [19:0] c;
        l = seed_of(i);
        s = '0;
        exp_op_q.delete();
        exp_sig_q.delete();
        for (int k = 0; k < nv_of(i); k++) begin
            exp_op_q.push_back(l);
            c = l[39:20] ^ l[19:0];
            s = model_misr(s, {(c == 20'h0), (fault ? 20'h0 : c)});
            l = model_lfsr(l);
        end
        exp_sig_q.push_back(s);
    endtask

    task automatic run(input int i, input bit fault, input bit mid_start);
        int          cyc;
        logic [39:0] e;
        logic [20:0] es;
        fault_w[i] = fault;
        build_expect(i, fault);
        @(negedge clk) start_w[i] = 1'b1;
        @(negedge clk) start_w[i] = 1'b0;
        chk("busy_first_cycle", busy_w[i], 1'b1);
        cyc = 0;
        while (busy_w[i] && cyc < 64) begin
            chk("vec_in_range", (cyc < nv_of(i)), 1'b1);
            if (exp_op_q.size() > 0) begin
                e = exp_op_q.pop_front();
                chk("op_a", op_a_w[i], e[39:20]);
                chk("op_b", op_b_w[i], e[19:0]);
            end
            chk("done_low_in_run", done_w[i], 1'b0);
            start_w[i] = (mid_start && cyc == 3);
            @(negedge clk);
            cyc++;
        end
        start_w[i] = 1'b0;
        chk("run_length", cyc, nv_of(i));
        chk("done_after_run", done_w[i], 1'b1);
        es = (exp_sig_q.size() > 0) ? exp_sig_q.pop_front() : 21'h1FFFFF;
        chk("signature", sig_w[i], es);
        chk("pass", pass_w[i], (es == gold_of(i)));
    endtask

    logic [20:0] saved_sig;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            fault_w[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_op_a", op_a_w[0], 20'h0);
        chk("rst_op_b", op_b_w[0], 20'h00001);
        chk("rst_busy", busy_w[0], 1'b0);
        chk("rst_done", done_w[0], 1'b0);
        chk("rst_pass", pass_w[0], 1'b0);
        chk("rst_sig", sig_w[0], 21'h0);
        chk("rst_seed10", {op_a_w[2], op_b_w[2]}, 40'hA5A5A_5C3C3);
        rst = 1'b0;

        run(0, 1'b0, 1'b0);
        chk("single_sig_const", sig_w[0], 21'h000001);
        chk("single_pass_const", pass_w[0], 1'b1);

        run(1, 1'b0, 1'b0);
        chk("two_sig_const", sig_w[1], 21'h000000);
        chk("two_pass_const", pass_w[1], 1'b1);

        run(0, 1'b1, 1'b0);
        chk("fault_sig_const", sig_w[0], 21'h000000);
        chk("fault_pass_const", pass_w[0], 1'b0);
        fault_w[0] = 1'b0;

        @(negedge clk) start_w[2] = 1'b1;
        @(negedge clk) start_w[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", busy_w[2], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy_w[2], 1'b0);
        chk("midrst_done", done_w[2], 1'b0);
        chk("midrst_sig", sig_w[2], 21'h0);
        chk("midrst_lfsr", {op_a_w[2], op_b_w[2]}, 40'hA5A5A_5C3C3);
        rst = 1'b0;

        run(2, 1'b0, 1'b0);
        saved_sig = sig_w[2];
        run(2, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);
        chk("restart_same_sig", sig_w[2], saved_sig);

        rst = 1'b1;
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        @(negedge clk);
        chk("rst_wins_busy", busy_w[0], 1'b0);
        chk("rst_wins_done", done_w[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", busy_w[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_logic_bist.md
# alu_logic_bist

Built-in self-test controller for the 20-bit ALU logic units (`xor_word` and its siblings). It drives pseudo-random operand pairs from an LFSR into a combinational logic unit, then compacts each `{zero, c}` result into a multiple-input signature register (MISR). After a fixed vector count it compares the signature against a golden value. It is the synthesizable counterpart of the operand drivers used on the logic-unit benches, and it sits beside the ALU for power-on or on-demand self-test.

## Interface
Parameters:
- `NUM_VECTORS`, default 10: vectors applied per run. Must be 1..1023.
- `SEED`, default 40'h00000_00001: LFSR start value. Must be nonzero; zero is an elaboration error.
- `GOLDEN_SIG`, default 21'h000000: expected final signature.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a run. Sampled in IDLE and DONE only.
- `op_a`  out  20: operand A to the unit under test. Equals `lfsr[39:20]`.
- `op_b`  out  20: operand B to the unit under test. Equals `lfsr[19:0]`.
- `res_c`  in  20: result word from the unit under test.
- `res_zero`  in  1: zero flag from the unit under test.
- `busy`  out  1: high while in RUN.
- `done`  out  1: high while in DONE.
- `pass`  out  1: valid only when `done` is high. 1 when `signature == GOLDEN_SIG`.
- `signature`  out  21: current MISR contents.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + `start`: load `lfsr <= SEED`, `sig <= 0`, `cnt <= 0`, go to RUN.
- RUN, every cycle:
  - Absorb `{res_zero, res_c}` into the MISR.
  - Step the LFSR.
  - `cnt <= cnt + 1`.
  - If `cnt == NUM_VECTORS-1`, go to DONE.
  - `start` is ignored.
- DONE: hold `sig`, `lfsr`, `pass`. `start` restarts exactly as from IDLE.
- LFSR: 40-bit Fibonacci, polynomial x^40+x^38+x^21+x^19+1. `lfsr_next = {lfsr[38:0], lfsr[39]^lfsr[37]^lfsr[20]^lfsr[18]}`.
- MISR: 21-bit, polynomial x^21+x^19+1. `sig_next = {sig[19:0], sig[20]^sig[18]} ^ {res_zero, res_c}`.
- `cnt`: 10 bits, saturates by construction. It never wraps within a run.
- Reset values:
  - state = IDLE
  - `lfsr` = SEED, so `op_a = SEED[39:20]` and `op_b = SEED[19:0]`
  - `sig` = 0
  - `cnt` = 0
  - `busy` = `done` = `pass` = 0
- Reset mid-run: returns to IDLE next edge. The partial signature is discarded.
- Simultaneous `rst` and `start`: reset wins.

## Timing
- The unit under test is combinational. The result for the operands presented in cycle N is sampled at the end of cycle N.
- `start` sampled at edge T:
  - RUN occupies cycles T+1 … T+NUM_VECTORS.
  - `busy` is high for exactly NUM_VECTORS cycles.
  - `done` and `pass` are valid from T+NUM_VECTORS+1 onward.
- Vector k (k = 0..NUM_VECTORS-1) is `SEED` stepped k times and is presented in cycle T+1+k.
- All outputs are registered, or are direct decodes of registered state or `lfsr` bits. There is no combinational path from any input to any output.
- Back-to-back runs: `start` held high in DONE re-enters RUN on the next edge, so `done` drops for the whole run.

## Structure
- Shared package `alu_pkg` holds:
  - `WORD_W` = 20, `LFSR_W` = 40, `SIG_W` = 21.
  - The LFSR tap indices {39,37,20,18} and MISR tap indices {20,18}.
  - The FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Encoding 2'd3 is illegal and recovers to IDLE.
- One sub-module, `bist_misr`:
  - Ports: `clk`, `rst`, `clr`, `en`, `din[20:0]`, `sig[20:0]`.
  - `clr` has priority over `en`.
  - It is reused by the arith-unit BIST.
- The LFSR, counter and FSM stay in `alu_logic_bist`.

## Test plan
- Reset check: assert `rst` for 2 cycles with SEED=40'h1. Require `op_a`=0, `op_b`=20'h00001, `busy`=`done`=`pass`=0, `signature`=0.
- Single vector: NUM_VECTORS=1, SEED=40'h1, GOLDEN_SIG=21'h000001, `xor_word` attached. Pulse `start`. Require:
  - `busy` for 1 cycle, with `op_a`=0, `op_b`=1 during it.
  - Then `done`=1, `signature`=21'h000001, `pass`=1.
- Two vectors: NUM_VECTORS=2, SEED=40'h1, `xor_word` attached. Require:
  - Second vector `op_b`=20'h00002.
  - Final `signature`=21'h000000, `pass`=1 with GOLDEN_SIG=0.
- Fault detection: same setup as the single-vector case, but force `res_c`=0. Require `signature`=0 and `pass`=0.
- Reset mid-run: NUM_VECTORS=10, assert `rst` in the 4th RUN cycle. Require IDLE next cycle, `signature`=0, `busy`=0. A following `start` completes normally in 10 cycles.
- Restart and ignore:
  - Pulse `start` during RUN: run length stays 10 cycles.
  - Pulse `start` in DONE: a new run begins the next cycle and produces the identical signature.
